// File: rtl/sc_dmem_io.sv
// sc_dmem_io -- data-side memory stage of the single-cycle CPU.
//   Word RAM, LED register, switch synchroniser, free-running timer and a
//   UART transmitter behind one word-addressed load/store port.
//   addr[1:0] is ignored for all accesses.
// Ports:
//   clock    system clock, all state updates on posedge
//   reset    synchronous, active-high
//   addr     byte address (CPU aluout)
//   datain   store data (CPU data)
//   we       store enable (CPU wmem)
//   dataout  load data, combinational from addr and current state
//   sw       asynchronous switch inputs
//   led      LED register
//   uart_tx  serial output, idle high
module sc_dmem_io #(
    parameter int unsigned RAM_AW       = 6,
    parameter int unsigned LED_W        = 8,
    parameter int unsigned SW_W         = 8,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       addr,
    input  logic [31:0]       datain,
    input  logic              we,
    output logic [31:0]       dataout,
    input  logic [SW_W-1:0]   sw,
    output logic [LED_W-1:0]  led,
    output logic              uart_tx
);

    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    // Word addresses (addr[31:2]) of the I/O registers
    localparam logic [29:0] W_LED   = 30'h3FFF_C000;
    localparam logic [29:0] W_SW    = 30'h3FFF_C001;
    localparam logic [29:0] W_UTX   = 30'h3FFF_C002;
    localparam logic [29:0] W_USTAT = 30'h3FFF_C003;
    localparam logic [29:0] W_TIMER = 30'h3FFF_C004;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

    logic [31:0]      ram [2**RAM_AW];
    logic             ram_sel;
    logic [29:0]      waddr;
    logic [SW_W-1:0]  sw_s1, sw_s2;
    logic [31:0]      timer;
    logic             utx_wr;

    uart_state_t      state, state_n;
    logic [BW-1:0]    baud, baud_n;
    logic [2:0]       bitidx, bitidx_n;
    logic [7:0]       txbyte, txbyte_n;
    logic             busy;

    logic             unused_addr;
    assign unused_addr = ^addr[1:0];

    assign waddr   = addr[31:2];
    assign ram_sel = (addr[31:RAM_AW+2] == '0);
    assign utx_wr  = we && (waddr == W_UTX);
    assign busy    = (state != S_IDLE);

    // RAM: write on edge, asynchronous read; contents are not reset
    always_ff @(posedge clock) begin
        if (we && ram_sel) begin
            ram[addr[RAM_AW+1:2]] <= datain;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            led   <= '0;
            sw_s1 <= '0;
            sw_s2 <= '0;
            timer <= '0;
        end else begin
            sw_s1 <= sw;
            sw_s2 <= sw_s1;
            if (we && (waddr == W_LED)) begin
                led <= datain[LED_W-1:0];
            end
            // A store to TIMER takes priority over the increment
            if (we && (waddr == W_TIMER)) begin
                timer <= '0;
            end else begin
                timer <= timer + 32'd1;
            end
        end
    end

    // UART state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= S_IDLE;
            baud   <= '0;
            bitidx <= '0;
            txbyte <= '0;
        end else begin
            state  <= state_n;
            baud   <= baud_n;
            bitidx <= bitidx_n;
            txbyte <= txbyte_n;
        end
    end

    // UART next state; only IDLE accepts a new byte, so stores while busy
    // (including the last STOP cycle) are dropped
    always_comb begin
        state_n  = state;
        baud_n   = baud;
        bitidx_n = bitidx;
        txbyte_n = txbyte;
        case (state)
            S_IDLE: begin
                if (utx_wr) begin
                    txbyte_n = datain[7:0];
                    baud_n   = '0;
                    bitidx_n = '0;
                    state_n  = S_START;
                end
            end
            S_START: begin
                if (baud == BAUD_LAST) begin
                    baud_n  = '0;
                    state_n = S_DATA;
                end else begin
                    baud_n = baud + BW'(1);
                end
            end
            S_DATA: begin
                if (baud == BAUD_LAST) begin
                    baud_n = '0;
                    if (bitidx == 3'd7) begin
                        bitidx_n = '0;
                        state_n  = S_STOP;
                    end else begin
                        bitidx_n = bitidx + 3'd1;
                    end
                end else begin
                    baud_n = baud + BW'(1);
                end
            end
            S_STOP: begin
                if (baud == BAUD_LAST) begin
                    baud_n  = '0;
                    state_n = S_IDLE;
                end else begin
                    baud_n = baud + BW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        uart_tx = 1'b1;
        case (state)
            S_START: uart_tx = 1'b0;
            S_DATA:  uart_tx = txbyte[bitidx];
            default: uart_tx = 1'b1;
        endcase
    end

    // Load path
    always_comb begin
        dataout = '0;
        if (ram_sel) begin
            dataout = ram[addr[RAM_AW+1:2]];
        end else begin
            case (waddr)
                W_LED:   dataout[LED_W-1:0] = led;
                W_SW:    dataout[SW_W-1:0]  = sw_s2;
                W_USTAT: dataout[0]         = busy;
                W_TIMER: dataout            = timer;
                default: dataout            = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_sc_dmem_io.sv
// tb_sc_dmem_io -- self-checking bench for sc_dmem_io (CLKS_PER_BIT=4).
//   Expected values go into a scoreboard queue as stimulus is driven and
//   are popped and compared when the DUT output is sampled.
module tb_sc_dmem_io;

    localparam int CPB = 4;
    localparam logic [31:0] A_LED   = 32'hFFFF_0000;
    localparam logic [31:0] A_SW    = 32'hFFFF_0004;
    localparam logic [31:0] A_UTX   = 32'hFFFF_0008;
    localparam logic [31:0] A_USTAT = 32'hFFFF_000C;
    localparam logic [31:0] A_TIMER = 32'hFFFF_0010;

    logic        clock  = 1'b0;
    logic        reset  = 1'b1;
    logic [31:0] addr   = '0;
    logic [31:0] datain = '0;
    logic        we     = 1'b0;
    logic [31:0] dataout;
    logic [7:0]  sw     = '0;
    logic [7:0]  led;
    logic        uart_tx;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];
    logic [31:0] got_q[$];

    always #5 clock = ~clock;

    sc_dmem_io #(
        .RAM_AW      (6),
        .LED_W       (8),
        .SW_W        (8),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .addr   (addr),
        .datain (datain),
        .we     (we),
        .dataout(dataout),
        .sw     (sw),
        .led    (led),
        .uart_tx(uart_tx)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sb_push(input string nm, input logic [31:0] v);
        exp_q.push_back(v);
        name_q.push_back(nm);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        we   = 1'b0;
        #1;
        d = dataout;
    endtask

    task automatic test_reset();
        logic [31:0] d, e, g;
        string nm;
        reset = 1'b1; we = 1'b0; addr = '0; datain = '0; sw = '0;
        tick(); tick();
        reset = 1'b0;
        sb_push("reset_led", 32'h0);
        sb_push("reset_tx", 32'h1);
        sb_push("reset_ustat", 32'h0);
        sb_push("reset_sw", 32'h0);
        sb_push("reset_timer", 32'h0);
        #1;
        got_q.push_back(32'(led));
        got_q.push_back(32'(uart_tx));
        rd(A_USTAT, d); got_q.push_back(d);
        rd(A_SW, d);    got_q.push_back(d);
        rd(A_TIMER, d); got_q.push_back(d);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); nm = name_q.pop_front(); g = got_q.pop_front();
            n_checks++;
            if (g !== e) $display("FAIL %s: got 0x%08h expected 0x%08h", nm, g, e);
            else n_pass++;
        end
        tick();
    endtask

    task automatic test_ram();
        logic [31:0] d, e, g;
        string nm;
        addr = 32'h8; datain = 32'hDEAD_BEEF; we = 1'b1;
        tick();
        addr = 32'h1000_0008; datain = 32'h1234_5678; we = 1'b1;   // unmapped
        tick();
        addr = 32'h0000_00FF; datain = 32'hCAFE_F00D; we = 1'b1;   // top word, low bits set
        tick();
        sb_push("ram_load_8", 32'hDEAD_BEEF);
        sb_push("ram_unmapped_read", 32'h0);
        sb_push("ram_top_word", 32'hCAFE_F00D);
        sb_push("ram_beyond_top", 32'h0);
        sb_push("ram_store_cycle_old", 32'hDEAD_BEEF);
        sb_push("ram_store_after_edge", 32'h0BAD_F00D);
        rd(32'h8, d);           got_q.push_back(d);
        rd(32'h1000_0000, d);   got_q.push_back(d);
        rd(32'h0000_00FC, d);   got_q.push_back(d);
        rd(32'h0000_0100, d);   got_q.push_back(d);
        addr = 32'h8; datain = 32'h0BAD_F00D; we = 1'b1;
        #1;
        got_q.push_back(dataout);
        tick();
        rd(32'h8, d);           got_q.push_back(d);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); nm = name_q.pop_front(); g = got_q.pop_front();
            n_checks++;
            if (g !== e) $display("FAIL %s: got 0x%08h expected 0x%08h", nm, g, e);
            else n_pass++;
        end
        tick();
    endtask

    task automatic test_led();
        logic [31:0] d, e, g;
        string nm;
        addr = A_LED; datain = 32'h0000_01A5; we = 1'b1;
        tick();
        we = 1'b0;
        sb_push("led_port", 32'hA5);
        sb_push("led_load", 32'hA5);
        sb_push("led_after_ro_writes", 32'hA5);
        sb_push("led_after_reset", 32'h0);
        #1;
        got_q.push_back(32'(led));
        rd(A_LED, d); got_q.push_back(d);
        addr = A_SW; datain = 32'hFFFF_FFFF; we = 1'b1;
        tick();
        addr = A_USTAT; we = 1'b1;
        tick();
        we = 1'b0;
        #1;
        got_q.push_back(32'(led));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        got_q.push_back(32'(led));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); nm = name_q.pop_front(); g = got_q.pop_front();
            n_checks++;
            if (g !== e) $display("FAIL %s: got 0x%08h expected 0x%08h", nm, g, e);
            else n_pass++;
        end
        // Still in the first cycle after reset; timer reads 0 here
    endtask

    // Entered in cycle 0 after a reset with sw=0 already synchronised.
    task automatic test_sw_timer();
        logic [31:0] d, e, g;
        string nm;
        sw = 8'h3C;
        for (int c = 0; c <= 5; c++) begin
            sb_push($sformatf("sw_c%0d", c), (c >= 2) ? 32'h3C : 32'h0);
            sb_push($sformatf("timer_c%0d", c), 32'(c));
            rd(A_SW, d);    got_q.push_back(d);
            rd(A_TIMER, d); got_q.push_back(d);
            if (c == 5) begin
                addr = A_TIMER; datain = 32'h0000_0077; we = 1'b1;
            end
            tick();
        end
        sb_push("timer_after_clear", 32'h0);
        rd(A_TIMER, d); got_q.push_back(d);
        tick();
        sb_push("timer_after_clear_p1", 32'h1);
        rd(A_TIMER, d); got_q.push_back(d);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); nm = name_q.pop_front(); g = got_q.pop_front();
            n_checks++;
            if (g !== e) $display("FAIL %s: got 0x%08h expected 0x%08h", nm, g, e);
            else n_pass++;
        end
        tick();
    endtask

    // Store byte b to UTX in cycle 0, then watch {busy, tx} for ncyc cycles.
    // In cycles inj_a/inj_b a store of 0x11 to UTX is issued instead of the
    // USTAT read (UTX itself reads 0). reset is pulsed in cycle rst_at.
    task automatic run_frame(input string tag, input logic [7:0] b, input int inj_a,
                             input int inj_b, input int rst_at, input int ncyc);
        logic [1:0]  x;
        logic [31:0] e, g;
        string nm;
        addr = A_UTX; datain = {24'h0, b}; we = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            if (rst_at >= 0 && c > rst_at)  x = 2'b01;
            else if (c <= CPB)              x = 2'b10;
            else if (c <= 9 * CPB)          x = {1'b1, b[(c - CPB - 1) / CPB]};
            else if (c <= 10 * CPB)         x = 2'b11;
            else                            x = 2'b01;
            if (c == inj_a || c == inj_b) x[1] = 1'b0;
            sb_push($sformatf("%s_c%0d", tag, c), 32'(x));
        end
        tick();
        for (int c = 1; c <= ncyc; c++) begin
            reset = (c == rst_at);
            if (c == inj_a || c == inj_b) begin
                addr = A_UTX; datain = 32'h0000_0011; we = 1'b1;
            end else begin
                addr = A_USTAT; we = 1'b0;
            end
            #1;
            g = {30'h0, dataout[0], uart_tx};
            e = exp_q.pop_front(); nm = name_q.pop_front();
            n_checks++;
            if (g !== e) $display("FAIL %s: got {busy,tx}=%02b expected %02b", nm, g[1:0], e[1:0]);
            else n_pass++;
            tick();
        end
        reset = 1'b0;
        we    = 1'b0;
    endtask

    task automatic test_uart_frame();
        run_frame("frame55", 8'h55, -1, -1, -1, 44);
    endtask

    task automatic test_uart_busy_drop();
        run_frame("drop", 8'h55, 20, 40, -1, 44);
    endtask

    task automatic test_uart_reset_mid();
        // DATA bit 3 occupies cycles 17..20
        run_frame("rstmid", 8'hA3, -1, -1, 18, 22);
        run_frame("after_rst", 8'h3C, -1, -1, -1, 44);
    endtask

    initial begin
        test_reset();
        test_ram();
        test_led();
        test_sw_timer();
        test_uart_frame();
        test_uart_busy_drop();
        test_uart_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
